// File: rtl/alu_driver.sv
// alu_driver: ALU command sequencer with sticky carry flag; define ALU_DRV_OVERLAP_EN to accept a command while the response is consumed
module alu_driver #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [4:0]       cmd_shamt,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  output logic [4:0]       alu_shamt,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_sign,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_sign,
  output logic             rsp_carry,
  output logic             rsp_illegal,
  output logic [TAG_W-1:0] rsp_tag
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t           r_state;
  logic             r_cmd_ready, r_rsp_valid;
  logic [31:0]      r_alu_a, r_alu_b, r_rsp_result;
  logic [3:0]       r_alu_op;
  logic [4:0]       r_alu_shamt;
  logic [TAG_W-1:0] r_tag, r_rsp_tag;
  logic             r_rsp_zero, r_rsp_sign, r_rsp_carry, r_rsp_illegal;
  logic             w_accept, w_consume, w_illegal;
`ifdef ALU_DRV_OVERLAP_EN
  assign cmd_ready = r_cmd_ready | (r_rsp_valid & rsp_ready);
`else
  assign cmd_ready = r_cmd_ready;
`endif
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_consume = r_rsp_valid & rsp_ready;
  assign w_illegal = (r_alu_op == 4'b0100) | (r_alu_op == 4'b0111);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_shamt   = r_alu_shamt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_zero    = r_rsp_zero;
  assign rsp_sign    = r_rsp_sign;
  assign rsp_carry   = r_rsp_carry;
  assign rsp_illegal = r_rsp_illegal;
  assign rsp_tag     = r_rsp_tag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_alu_shamt   <= '0;
      r_tag         <= '0;
      r_rsp_result  <= '0;
      r_rsp_zero    <= 1'b0;
      r_rsp_sign    <= 1'b0;
      r_rsp_carry   <= 1'b0;
      r_rsp_illegal <= 1'b0;
      r_rsp_tag     <= '0;
    end else if (r_state == ISSUE) begin
      r_state       <= RESP;
      r_rsp_valid   <= 1'b1;
      r_rsp_result  <= alu_result;
      r_rsp_zero    <= alu_zero;
      r_rsp_sign    <= alu_sign;
      r_rsp_illegal <= w_illegal;
      r_rsp_tag     <= r_tag;
      // carry is architectural state: only an add may change it
      if (r_alu_op == 4'b0001) r_rsp_carry <= alu_carry;
    end else if (w_accept) begin
      r_state     <= ISSUE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_alu_a     <= cmd_a;
      r_alu_b     <= cmd_b;
      r_alu_op    <= cmd_op;
      r_alu_shamt <= cmd_shamt;
      r_tag       <= cmd_tag;
    end else if (w_consume) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
    end
  end
endmodule
